// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and the counter sizing helper for the
// multi-channel button debouncer.
package debounce_pkg;

  // 10 ms and 0.5 s at a 100 MHz system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 50_000_000;

  // Depth of the per-bit input synchronizer.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of a counter that must be able to represent max_count.
  // Never returns 0, so a degenerate parameter still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel -- synchronizer, debounce counter,
// registered edge pulses and an optional long-press pulse.
// Long-press logic is built only when DEBOUNCE_HOLD_EN is defined; otherwise
// btn_hold is tied low and no hold counter exists.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_stable,
  output logic btn_stable_posedge,
  output logic btn_stable_negedge,
  output logic btn_hold
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard against parameter values that make no sense.
  if (DEBOUNCE_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_bad_params
    $error("debounce_chan: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_pos;
  logic                   r_neg;
  logic                   w_differ;
  logic                   w_accept;

  // Two-flop synchronizer bringing the raw button into the clk domain.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the values from before the edge; the synchronizer is reset like the rest
  // so reset release cannot present a stale level to the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_stable);
  // The new level has now been seen for DEBOUNCE_CYCLES consecutive edges.
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Debounce counter, accepted level and the one-cycle edge pulses.
  // The counter clears on acceptance or whenever the input agrees with the
  // accepted level, so it tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_pos <= w_accept && !r_stable;
      r_neg <= w_accept &&  r_stable;
      if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_stable         = r_stable;
  assign btn_stable_posedge = r_pos;
  assign btn_stable_negedge = r_neg;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic [HW-1:0] r_hold_cnt;
  logic          r_hold;

  // Long-press detector: saturating count of cycles with the accepted level
  // high; the pulse fires as the count steps onto HOLD_CYCLES, and saturation
  // keeps it to a single pulse per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= r_stable && (r_hold_cnt == HOLD_LAST);
      if (!r_stable) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign btn_hold = r_hold;
`else
  assign btn_hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent debounced button channels.
// Optional long-press pulses are enabled by defining DEBOUNCE_HOLD_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_stable,
  output logic [N_CH-1:0] btn_stable_posedge,
  output logic [N_CH-1:0] btn_stable_negedge,
  output logic [N_CH-1:0] btn_hold
);

  // Elaboration-time guard: at least one channel is required.
  if (N_CH == 0) begin : g_bad_nch
    $error("debounce_multi: N_CH must be >= 1");
  end

  // One self-contained channel per button; no state is shared between them.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_chan (
      .clk                (clk),
      .rst                (rst),
      .btn                (btn[i]),
      .btn_stable         (btn_stable[i]),
      .btn_stable_posedge (btn_stable_posedge[i]),
      .btn_stable_negedge (btn_stable_negedge[i]),
      .btn_hold           (btn_hold[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: self-checking bench for debounce_multi with N_CH=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=10. Long-press expectations follow
// DEBOUNCE_HOLD_EN.
`timescale 1ns/1ps
module tb_debounce_multi;

  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
`ifdef DEBOUNCE_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] stable;
    logic [1:0] pos;
    logic [1:0] neg;
    logic [1:0] hold;
  } out_t;

  // One stimulus segment: btn level held for a number of cycles, with the
  // accepted level at its end and which channels must have pulsed inside it.
  typedef struct {
    logic [1:0] btn;
    int         cycles;
    logic [1:0] exp_stable;
    logic [1:0] exp_pos;
    logic [1:0] exp_neg;
  } seg_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] btn_stable;
  logic [1:0] btn_stable_posedge;
  logic [1:0] btn_stable_negedge;
  logic [1:0] btn_hold;

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t exp_q[$];

  // Reference model state: accepted levels, btn history as sampled at each
  // edge, edge counter and the edge at which each channel last rose.
  logic [1:0] m_stable;
  logic [1:0] m_hist[$];
  int         m_edge;
  int         m_rise[2];

  debounce_multi #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn                (btn),
    .btn_stable         (btn_stable),
    .btn_stable_posedge (btn_stable_posedge),
    .btn_stable_negedge (btn_stable_negedge),
    .btn_hold           (btn_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Spec-level model of one clock edge: a channel accepts a new level when
  // the synchronized input (btn two edges back) has shown that level for the
  // last DEB edges.
  task automatic model_edge(input logic [1:0] b, input logic r, output out_t o);
    o = '0;
    m_edge++;
    if (!r) begin
      m_stable = 2'b00;
      m_hist.delete();
      for (int k = 0; k < DEB + 2; k++) m_hist.push_back(2'b00);
      m_rise[0] = -1;
      m_rise[1] = -1;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        logic nv;
        logic all_new;
        nv      = ~m_stable[ch];
        all_new = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (m_hist[m_hist.size() - k][ch] != nv) all_new = 1'b0;
        if (HOLD_ON && m_stable[ch] && m_rise[ch] >= 0 && (m_edge - m_rise[ch]) == HOLD)
          o.hold[ch] = 1'b1;
        if (all_new) begin
          o.pos[ch]      = nv;
          o.neg[ch]      = ~nv;
          m_stable[ch]   = nv;
          m_rise[ch]     = nv ? m_edge : -1;
        end
      end
      m_hist.push_back(b);
      if (m_hist.size() > DEB + 4) void'(m_hist.pop_front());
    end
    o.stable = m_stable;
  endtask

  // Drive one cycle of stimulus at the falling edge, queue the expected
  // outputs, then compare just after the next rising edge.
  task automatic drive(input logic [1:0] b, input logic r, input string name, output out_t act);
    out_t e;
    @(negedge clk);
    btn = b;
    rst = r;
    model_edge(b, r, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act = {btn_stable, btn_stable_posedge, btn_stable_negedge, btn_hold};
    e   = exp_q.pop_front();
    check(name, act, e);
  endtask

  seg_t segs[9];

  initial begin
    out_t       a;
    logic [1:0] seen_pos;
    logic [1:0] seen_neg;
    int         rise_at, fall_at, pos_at, neg_at, hold_at;
    int         n_pos, n_neg, n_hold;
    logic [1:0] pos_val, neg_val;

    // idle, ch1 glitch of 3 cycles, then btn[0] bouncing every 2 cycles
    segs[0] = '{2'b00, 6, 2'b00, 2'b00, 2'b00};
    segs[1] = '{2'b10, 3, 2'b00, 2'b00, 2'b00};
    segs[2] = '{2'b00, 8, 2'b00, 2'b00, 2'b00};
    segs[3] = '{2'b01, 2, 2'b00, 2'b00, 2'b00};
    segs[4] = '{2'b00, 2, 2'b00, 2'b00, 2'b00};
    segs[5] = '{2'b01, 2, 2'b00, 2'b00, 2'b00};
    segs[6] = '{2'b00, 2, 2'b00, 2'b00, 2'b00};
    segs[7] = '{2'b01, 2, 2'b00, 2'b00, 2'b00};
    segs[8] = '{2'b00, 2, 2'b00, 2'b00, 2'b00};

    rst = 1'b0;
    btn = 2'b00;
    m_rise[0] = -1;
    m_rise[1] = -1;
    m_edge = 0;
    m_stable = 2'b00;

    // Reset with buttons pressed: everything stays low.
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 1'b0, "reset_cycle", a);
      check("reset_outputs", a, 8'h00);
    end

    // Table-driven segments (first one releases reset).
    for (int s = 0; s < 9; s++) begin
      seen_pos = 2'b00;
      seen_neg = 2'b00;
      for (int c = 0; c < segs[s].cycles; c++) begin
        drive(segs[s].btn, 1'b1, $sformatf("seg%0d_cycle%0d", s, c), a);
        seen_pos |= a.pos;
        seen_neg |= a.neg;
      end
      check($sformatf("seg%0d_stable", s), a.stable, segs[s].exp_stable);
      check($sformatf("seg%0d_pos", s), seen_pos, segs[s].exp_pos);
      check($sformatf("seg%0d_neg", s), seen_neg, segs[s].exp_neg);
    end

    // Final edge of the bounce, then a long press.
    rise_at = -1; pos_at = -1; hold_at = -1;
    n_pos = 0; n_neg = 0; n_hold = 0;
    for (int k = 1; k <= 30; k++) begin
      drive(2'b01, 1'b1, "press", a);
      if (a.stable[0] && rise_at < 0) rise_at = k;
      if (a.pos[0]) begin n_pos++; if (pos_at < 0) pos_at = k; end
      if (a.neg[0]) n_neg++;
      if (a.hold[0]) begin n_hold++; if (hold_at < 0) hold_at = k; end
    end
    check("press_rise_at", rise_at, 6);
    check("press_pos_at", pos_at, 6);
    check("press_pos_count", n_pos, 1);
    check("press_neg_count", n_neg, 0);
    check("hold_count", n_hold, HOLD_ON ? 1 : 0);
    check("hold_at", hold_at, HOLD_ON ? 6 + HOLD : -1);

    // Release.
    fall_at = -1; neg_at = -1;
    n_pos = 0; n_neg = 0; n_hold = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(2'b00, 1'b1, "release", a);
      if (!a.stable[0] && fall_at < 0) fall_at = k;
      if (a.neg[0]) begin n_neg++; if (neg_at < 0) neg_at = k; end
      if (a.pos[0]) n_pos++;
      if (a.hold[0]) n_hold++;
    end
    check("release_neg_at", neg_at, 6);
    check("release_fall_at", fall_at, 6);
    check("release_neg_count", n_neg, 1);
    check("release_pos_count", n_pos, 0);
    check("release_hold_count", n_hold, 0);

    // Both channels pressed on the same cycle, then released together.
    pos_at = -1; pos_val = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      drive(2'b11, 1'b1, "simul_press", a);
      if (a.pos != 2'b00 && pos_at < 0) begin pos_at = k; pos_val = a.pos; end
    end
    check("simul_pos_at", pos_at, 6);
    check("simul_pos_val", pos_val, 2'b11);
    neg_at = -1; neg_val = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      drive(2'b00, 1'b1, "simul_release", a);
      if (a.neg != 2'b00 && neg_at < 0) begin neg_at = k; neg_val = a.neg; end
    end
    check("simul_neg_at", neg_at, 6);
    check("simul_neg_val", neg_val, 2'b11);

    // Reset while both counters are at 3, then release with buttons held.
    for (int k = 1; k <= 5; k++) drive(2'b11, 1'b1, "midcount", a);
    for (int k = 1; k <= 2; k++) begin
      drive(2'b11, 1'b0, "midcount_reset", a);
      check("midcount_reset_outputs", a, 8'h00);
    end
    pos_at = -1; pos_val = 2'b00; n_neg = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(2'b11, 1'b1, "after_reset", a);
      if (a.pos != 2'b00 && pos_at < 0) begin pos_at = k; pos_val = a.pos; end
      if (a.neg != 2'b00) n_neg++;
    end
    check("after_reset_pos_at", pos_at, 6);
    check("after_reset_pos_val", pos_val, 2'b11);
    check("after_reset_neg_count", n_neg, 0);

    for (int k = 1; k <= 10; k++) drive(2'b00, 1'b1, "drain", a);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
